// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, single outstanding imem request, 2-entry {ins, pc} buffer
// Redirect flushes the buffer; a request in flight at redirect time is drained and its ack dropped.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc
);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        req_q, req_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic        push, pop;
  logic [1:0]  unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    ins0_d  = ins0_q;
    ins1_d  = ins1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    push    = (state_q == FETCH) && req_q && imem_ack && !redirect;
    pop     = (count_q != 2'd0) && ins_ready && !redirect;

    if (redirect) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      if (state_q == FETCH && req_q && !imem_ack)
        state_d = DRAIN;
      else if (state_q == DRAIN && imem_ack)
        state_d = FETCH;
    end else begin
      if (state_q == DRAIN && imem_ack)
        state_d = FETCH;
      if (push)
        pc_d = pc_q + 32'd4;
      // Entry 0 is always the head; entry 1 shifts down on pop.
      case ({push, pop})
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) begin
            ins0_d = imem_data;
            pc0_d  = pc_q;
          end else begin
            ins1_d = imem_data;
            pc1_d  = pc_q;
          end
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          ins0_d  = ins1_q;
          pc0_d   = pc1_q;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ins0_d = imem_data;
            pc0_d  = pc_q;
          end else begin
            ins0_d = ins1_q;
            pc0_d  = pc1_q;
            ins1_d = imem_data;
            pc1_d  = pc_q;
          end
        end
        default: ;
      endcase
    end

    // Registered request: cannot rise until the first edge after reset.
    req_d = (state_d == FETCH) && (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
      count_q <= 2'd0;
      req_q   <= 1'b0;
      ins0_q  <= 32'd0;
      ins1_q  <= 32'd0;
      pc0_q   <= 32'd0;
      pc1_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      req_q   <= req_d;
      ins0_q  <= ins0_d;
      ins1_q  <= ins1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ins_valid = (count_q != 2'd0);
  assign ins       = ins_valid ? ins0_q : 32'd0;
  assign ins_pc    = ins_valid ? pc0_q : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a queue-based reference model
// Inputs change on the falling edge; outputs are compared there and just after rising edges.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;

  int checks;
  int failures;

  // Reference model: fetch address, pending-drain flag, and buffer as a queue of {word, pc}.
  logic [31:0] m_pc;
  bit          m_drain;
  bit          m_started;
  logic [63:0] m_q[$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins(ins), .ins_pc(ins_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  function automatic bit m_req();
    return m_started && !m_drain && (m_q.size() < 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    m_drain = 1'b0;
    m_started = 1'b0;
    m_q.delete();
  endtask

  task automatic cycle(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit req;
    bit popped;
    bit pushed;
    @(negedge clk);
    req = m_req();
    imem_ack    = ack;
    imem_data   = (req && ack) ? memword(m_pc) : 32'hDEADBEEF;
    ins_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    chk("cyc_imem_req", {31'd0, imem_req}, {31'd0, req});
    chk("cyc_imem_addr", imem_addr, m_pc);
    chk("cyc_ins_valid", {31'd0, ins_valid}, {31'd0, m_q.size() != 0});
    chk("cyc_ins", ins, (m_q.size() != 0) ? m_q[0][63:32] : 32'd0);
    chk("cyc_ins_pc", ins_pc, (m_q.size() != 0) ? m_q[0][31:0] : 32'd0);
    @(posedge clk);
    if (redir) begin
      if (!m_drain && req && !ack) m_drain = 1'b1;
      else if (m_drain && ack) m_drain = 1'b0;
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      popped = (m_q.size() != 0) && rdy;
      pushed = !m_drain && req && ack;
      if (m_drain && ack) m_drain = 1'b0;
      if (popped) void'(m_q.pop_front());
      if (pushed) begin
        m_q.push_back({memword(m_pc), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_started = 1'b1;
    #1;
  endtask

  task automatic quiet_inputs();
    imem_ack = 1'b0;
    imem_data = 32'd0;
    ins_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    quiet_inputs();
    #1;
    chk("rst_async_ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_async_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_async_pc", imem_addr, 32'h0);
    chk("rst_async_ins", ins, 32'h0);
    chk("rst_async_ins_pc", ins_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_release_req_low", {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
    chk("reset_ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("reset_imem_addr", imem_addr, 32'h0);
    chk("reset_ins", ins, 32'h0);
    chk("reset_ins_pc", ins_pc, 32'h0);
    rst = 1'b0;
    #1;
    chk("release_req_low", {31'd0, imem_req}, 32'd0);

    // Streaming: one instruction per cycle from 0x0.
    cycle(0, 1, 0, 0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    cycle(1, 1, 0, 0);
    chk("stream_pc0", ins_pc, 32'h0);
    chk("stream_ins0", ins, memword(32'h0));
    cycle(1, 1, 0, 0);
    chk("stream_pc4", ins_pc, 32'h4);
    cycle(1, 1, 0, 0);
    chk("stream_pc8", ins_pc, 32'h8);
    chk("stream_ins8", ins, memword(32'h8));

    // Asynchronous reset while one entry is buffered.
    async_reset();

    // Backpressure: buffer fills, request drops, one pop re-requests 0x8.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("full_req_low", {31'd0, imem_req}, 32'd0);
    chk("full_addr", imem_addr, 32'h8);
    chk("full_head_pc", ins_pc, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("pop_req_high", {31'd0, imem_req}, 32'd1);
    chk("pop_addr", imem_addr, 32'h8);
    chk("pop_head_pc", ins_pc, 32'h4);
    cycle(1, 0, 0, 0);

    // Redirect with a full buffer and no request in flight.
    cycle(0, 0, 1, 32'h00000103);
    chk("redir_full_valid", {31'd0, ins_valid}, 32'd0);
    chk("redir_full_addr", imem_addr, 32'h100);
    chk("redir_full_req", {31'd0, imem_req}, 32'd1);

    // Redirect with request pending: drain, second redirect in drain, late ack dropped.
    cycle(0, 1, 1, 32'h00000200);
    chk("drain_req_low", {31'd0, imem_req}, 32'd0);
    chk("drain_addr", imem_addr, 32'h200);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h0000030A);
    chk("drain_redir_addr", imem_addr, 32'h308);
    chk("drain_redir_req", {31'd0, imem_req}, 32'd0);
    cycle(1, 1, 0, 0);
    chk("drain_ack_valid", {31'd0, ins_valid}, 32'd0);
    chk("drain_ack_req", {31'd0, imem_req}, 32'd1);
    chk("drain_ack_addr", imem_addr, 32'h308);
    cycle(1, 1, 0, 0);
    chk("after_drain_pc", ins_pc, 32'h308);
    chk("after_drain_ins", ins, memword(32'h308));

    // Redirect in the same cycle as an ack: ack discarded.
    cycle(1, 0, 1, 32'hFFFFFFF8);
    chk("redir_ack_valid", {31'd0, ins_valid}, 32'd0);
    chk("redir_ack_addr", imem_addr, 32'hFFFFFFF8);

    // PC wraps modulo 2^32.
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("wrap_entry_pc", ins_pc, 32'hFFFFFFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    cycle(1, 1, 0, 0);
    chk("wrap_next_pc", ins_pc, 32'h0);
    cycle(0, 1, 0, 0);
    chk("empty_ins", ins, 32'h0);
    chk("empty_ins_pc", ins_pc, 32'h0);
    chk("empty_valid", {31'd0, ins_valid}, 32'd0);
    cycle(0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
